// File: rtl/controle_estacionamento_nvias.sv
// Multi-gate parking-lot controller.
// Each gate runs its own Moore direction-detection FSM on the sensor pair {A,B}.
// A gate that stalls mid-passage aborts after a per-gate timeout.
// Completed passages from all gates feed one shared, saturating occupancy counter.
module controle_estacionamento_nvias #(
   parameter int N_PORTOES  = 2,
   parameter int CAPACIDADE = 100,
   parameter int LARGURA    = 8,
   parameter int TIMEOUT    = 1000
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [N_PORTOES-1:0] A,
   input  logic [N_PORTOES-1:0] B,
   output logic [N_PORTOES-1:0] entrou,
   output logic [N_PORTOES-1:0] saiu,
   output logic [N_PORTOES-1:0] abortou,
   output logic [LARGURA-1:0]   ocupacao,
   output logic                 cheio,
   output logic                 vazio,
   output logic                 erro_sat
);

   // A zero timeout still needs a 1-bit timer so that the declaration stays legal.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Wide enough for count + delta without any intermediate wrap, plus a sign bit.
   localparam int SW = LARGURA + $clog2(N_PORTOES + 1) + 2;
   localparam logic signed [SW-1:0] CAP_S = SW'(CAPACIDADE);
   localparam logic signed [SW-1:0] UM_S  = SW'(1);

   typedef enum logic [3:0] {
      IDLE, E1, E2, E3, ENT, S1, S2, S3, SAI, ABT
   } estado_t;

   for (genvar g = 0; g < N_PORTOES; g++) begin : g_portao
      estado_t       estado_q, estado_d, prox;
      logic [TW-1:0] timer_q, timer_d;
      logic [1:0]    ab;

      assign ab = {A[g], B[g]};

      // Next state from the transition table, then the stall timeout overrides it.
      always_comb begin
         // NOTE: every combinational output gets a default first so no path can infer a latch.
         prox     = estado_q;
         estado_d = estado_q;
         timer_d  = '0;
         unique case (estado_q)
            IDLE:    prox = (ab == 2'b10) ? E1 : (ab == 2'b01) ? S1 : IDLE;
            E1:      prox = (ab == 2'b10) ? E1 : (ab == 2'b11) ? E2 : IDLE;
            E2:      prox = (ab == 2'b11) ? E2 : (ab == 2'b10) ? E1 :
                            (ab == 2'b01) ? E3 : IDLE;
            E3:      prox = (ab == 2'b01) ? E3 : (ab == 2'b11) ? E2 :
                            (ab == 2'b00) ? ENT : IDLE;
            S1:      prox = (ab == 2'b01) ? S1 : (ab == 2'b11) ? S2 : IDLE;
            S2:      prox = (ab == 2'b11) ? S2 : (ab == 2'b01) ? S1 :
                            (ab == 2'b10) ? S3 : IDLE;
            S3:      prox = (ab == 2'b10) ? S3 : (ab == 2'b11) ? S2 :
                            (ab == 2'b00) ? SAI : IDLE;
            default: prox = IDLE;   // ENT, SAI, ABT and unused encodings
         endcase
         estado_d = prox;
         // Only the mid-passage states can stay put, so only they count time.
         if (TIMEOUT > 0 && prox == estado_q && estado_q != IDLE) begin
            if (int'(timer_q) == TIMEOUT - 1) estado_d = ABT;
            else                              timer_d  = timer_q + TW'(1);
         end
      end

      // Gate state and timer registers.
      always_ff @(posedge CLK or posedge reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         if (reset) begin
            estado_q <= IDLE;
            timer_q  <= '0;
         end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
         end
      end

      assign entrou[g]  = (estado_q == ENT);
      assign saiu[g]    = (estado_q == SAI);
      assign abortou[g] = (estado_q == ABT);
   end

   logic [LARGURA-1:0]   ocupacao_q, ocupacao_d;
   logic                 erro_sat_q, erro_sat_d;
   logic signed [SW-1:0] delta, soma;

   // Net change of all gates this cycle, then clamp into [0, CAPACIDADE].
   always_comb begin
      delta      = '0;
      ocupacao_d = ocupacao_q;
      erro_sat_d = 1'b0;
      for (int g = 0; g < N_PORTOES; g++) begin
         if (entrou[g]) delta = delta + UM_S;
         if (saiu[g])   delta = delta - UM_S;
      end
      soma = $signed({{(SW - LARGURA){1'b0}}, ocupacao_q}) + delta;
      if (soma < 0) begin
         ocupacao_d = '0;
         erro_sat_d = 1'b1;
      end else if (soma > CAP_S) begin
         ocupacao_d = LARGURA'(CAPACIDADE);
         erro_sat_d = 1'b1;
      end else begin
         ocupacao_d = soma[LARGURA-1:0];
      end
   end

   // Occupancy count and the clamp pulse, registered together.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         ocupacao_q <= '0;
         erro_sat_q <= 1'b0;
      end else begin
         ocupacao_q <= ocupacao_d;
         erro_sat_q <= erro_sat_d;
      end
   end

   assign ocupacao = ocupacao_q;
   assign erro_sat = erro_sat_q;
   assign cheio    = (ocupacao_q == LARGURA'(CAPACIDADE));
   assign vazio    = (ocupacao_q == '0);

endmodule

// File: tb/tb_controle_estacionamento_nvias.sv
// Bench for controle_estacionamento_nvias (2 gates, capacity 3, timeout 8).
// Expected gate pulses are queued when a passage is driven and popped by a monitor.
// A second instance with the timeout disabled sees the same sensors.
module tb_controle_estacionamento_nvias;

   logic       CLK = 1'b0;
   logic       reset;
   logic [1:0] A, B;
   logic [1:0] entrou, saiu, abortou;
   logic [7:0] ocupacao;
   logic       cheio, vazio, erro_sat;

   logic [1:0] entrou_nt, saiu_nt, abortou_nt;
   logic [7:0] ocupacao_nt;
   logic       cheio_nt, vazio_nt, erro_sat_nt;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [1:0] ent;
      logic [1:0] sai;
      logic [1:0] abt;
   } pulso_t;

   pulso_t esperado[$];

   controle_estacionamento_nvias #(
      .N_PORTOES(2), .CAPACIDADE(3), .LARGURA(8), .TIMEOUT(8)
   ) dut (
      .CLK(CLK), .reset(reset), .A(A), .B(B),
      .entrou(entrou), .saiu(saiu), .abortou(abortou),
      .ocupacao(ocupacao), .cheio(cheio), .vazio(vazio), .erro_sat(erro_sat)
   );

   controle_estacionamento_nvias #(
      .N_PORTOES(2), .CAPACIDADE(3), .LARGURA(8), .TIMEOUT(0)
   ) dut_nt (
      .CLK(CLK), .reset(reset), .A(A), .B(B),
      .entrou(entrou_nt), .saiu(saiu_nt), .abortou(abortou_nt),
      .ocupacao(ocupacao_nt), .cheio(cheio_nt), .vazio(vazio_nt), .erro_sat(erro_sat_nt)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: every gate pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (!reset) begin
         if ((entrou | saiu | abortou) != 2'b00) begin
            checks++;
            if (esperado.size() == 0) begin
               errors++;
               $display("FAIL pulse_unexpected: got ent=%b sai=%b abt=%b, required none", entrou, saiu, abortou);
            end else begin
               pulso_t p;
               p = esperado.pop_front();
               if ({entrou, saiu, abortou} !== p) begin
                  errors++;
                  $display("FAIL pulse_match: got ent=%b sai=%b abt=%b, required ent=%b sai=%b abt=%b",
                           entrou, saiu, abortou, p.ent, p.sai, p.abt);
               end
            end
         end
         if (abortou_nt !== 2'b00) begin
            checks++;
            errors++;
            $display("FAIL abort_disabled: got abortou=%b, required 00", abortou_nt);
         end
      end
   end

   // Drive both sensor vectors for one clock edge; return 1 time unit after it.
   task automatic passo(input logic [1:0] a_v, input logic [1:0] b_v);
      A = a_v;
      B = b_v;
      @(posedge CLK);
      #1;
   endtask

   // Drive one gate's {A,B} pair, other gate clear.
   task automatic passo_g(input int g, input logic [1:0] ab);
      logic [1:0] a_v, b_v;
      a_v = 2'b00;
      b_v = 2'b00;
      a_v[g] = ab[1];
      b_v[g] = ab[0];
      passo(a_v, b_v);
   endtask

   task automatic chk_occ(input string nome, input logic [7:0] occ, input logic ch,
                          input logic vz, input logic es);
      checks++;
      if (ocupacao !== occ || cheio !== ch || vazio !== vz || erro_sat !== es) begin
         errors++;
         $display("FAIL %s: got occ=%0d cheio=%b vazio=%b erro_sat=%b, required occ=%0d cheio=%b vazio=%b erro_sat=%b",
                  nome, ocupacao, cheio, vazio, erro_sat, occ, ch, vz, es);
      end
   endtask

   task automatic chk_fila(input string nome);
      checks++;
      if (esperado.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d pending pulses, required 0", nome, esperado.size());
         esperado.delete();
      end
   endtask

   task automatic entrada(input int g);
      passo_g(g, 2'b10);
      passo_g(g, 2'b11);
      passo_g(g, 2'b01);
      esperado.push_back(pulso_t'({2'(1 << g), 2'b00, 2'b00}));
      passo_g(g, 2'b00);
   endtask

   task automatic saida(input int g);
      passo_g(g, 2'b01);
      passo_g(g, 2'b11);
      passo_g(g, 2'b10);
      esperado.push_back(pulso_t'({2'b00, 2'(1 << g), 2'b00}));
      passo_g(g, 2'b00);
   endtask

   task automatic test_reset;
      A = 2'b00;
      B = 2'b00;
      reset = 1'b1;
      #2;
      checks++;
      if ({entrou, saiu, abortou} !== 6'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b, required 000000", {entrou, saiu, abortou});
      end
      chk_occ("reset_occ", 8'd0, 1'b0, 1'b1, 1'b0);
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_entry;
      entrada(0);
      checks++;
      if (entrou !== 2'b01) begin
         errors++;
         $display("FAIL entry_pulse: got entrou=%b, required 01", entrou);
      end
      chk_occ("entry_occ_lag", 8'd0, 1'b0, 1'b1, 1'b0);
      passo(2'b00, 2'b00);
      chk_occ("entry_occ", 8'd1, 1'b0, 1'b0, 1'b0);
      chk_fila("entry_queue");
   endtask

   task automatic test_exit_and_underflow;
      saida(1);
      passo(2'b00, 2'b00);
      chk_occ("exit_occ", 8'd0, 1'b0, 1'b1, 1'b0);
      saida(1);
      passo(2'b00, 2'b00);
      chk_occ("underflow_clamp", 8'd0, 1'b0, 1'b1, 1'b1);
      passo(2'b00, 2'b00);
      chk_occ("underflow_pulse_end", 8'd0, 1'b0, 1'b1, 1'b0);
      chk_fila("exit_queue");
   endtask

   task automatic test_reversal;
      passo_g(0, 2'b10);
      passo_g(0, 2'b11);
      passo_g(0, 2'b10);
      passo_g(0, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("reversal_none", 8'd0, 1'b0, 1'b1, 1'b0);
      passo_g(0, 2'b10);
      passo_g(0, 2'b11);
      passo_g(0, 2'b01);
      passo_g(0, 2'b11);
      passo_g(0, 2'b01);
      esperado.push_back(pulso_t'({2'b01, 2'b00, 2'b00}));
      passo_g(0, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("reversal_entry", 8'd1, 1'b0, 1'b0, 1'b0);
      chk_fila("reversal_queue");
   endtask

   task automatic test_back_to_back;
      entrada(1);
      passo(2'b00, 2'b00);
      chk_occ("second_entry", 8'd2, 1'b0, 1'b0, 1'b0);
      // Both gates enter together: 2 + 2 clamps to 3.
      passo(2'b11, 2'b00);
      passo(2'b11, 2'b11);
      passo(2'b00, 2'b11);
      esperado.push_back(pulso_t'({2'b11, 2'b00, 2'b00}));
      passo(2'b00, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("overflow_clamp", 8'd3, 1'b1, 1'b0, 1'b1);
      // Gate 0 enters while gate 1 exits: nets to zero at full.
      passo(2'b01, 2'b10);
      passo(2'b11, 2'b11);
      passo(2'b10, 2'b01);
      esperado.push_back(pulso_t'({2'b01, 2'b10, 2'b00}));
      passo(2'b00, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("net_zero_full", 8'd3, 1'b1, 1'b0, 1'b0);
      chk_fila("b2b_queue");
   endtask

   task automatic test_timeout;
      passo_g(0, 2'b10);
      for (int i = 0; i < 8; i++) passo_g(0, 2'b11);
      checks++;
      if (abortou !== 2'b00) begin
         errors++;
         $display("FAIL abort_early: got abortou=%b, required 00", abortou);
      end
      esperado.push_back(pulso_t'({2'b00, 2'b00, 2'b01}));
      passo_g(0, 2'b11);
      checks++;
      if (abortou !== 2'b01 || abortou_nt !== 2'b00) begin
         errors++;
         $display("FAIL abort_pulse: got abortou=%b abortou_nt=%b, required 01 and 00", abortou, abortou_nt);
      end
      passo_g(0, 2'b11);
      checks++;
      if (abortou !== 2'b00) begin
         errors++;
         $display("FAIL abort_width: got abortou=%b, required 00", abortou);
      end
      passo(2'b00, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("abort_no_count", 8'd3, 1'b1, 1'b0, 1'b0);
      chk_fila("abort_queue");
   endtask

   task automatic test_async_reset;
      saida(1);
      passo(2'b00, 2'b00);
      chk_occ("pre_reset_occ", 8'd2, 1'b0, 1'b0, 1'b0);
      passo_g(0, 2'b10);
      passo_g(0, 2'b11);
      passo_g(0, 2'b01);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({entrou, saiu, abortou} !== 6'b0) begin
         errors++;
         $display("FAIL async_reset_pulses: got %b, required 000000", {entrou, saiu, abortou});
      end
      chk_occ("async_reset_occ", 8'd0, 1'b0, 1'b1, 1'b0);
      @(posedge CLK);
      #1;
      reset = 1'b0;
      passo_g(0, 2'b00);
      passo(2'b00, 2'b00);
      chk_occ("post_reset_no_entry", 8'd0, 1'b0, 1'b1, 1'b0);
      chk_fila("reset_queue");
   endtask

   initial begin
      test_reset();
      test_entry();
      test_exit_and_underflow();
      test_reversal();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/controle_estacionamento_nvias.md
Name: controle_estacionamento_nvias

Overview:
Multi-gate parking-lot controller and the parametrised successor of the single-gate entry/exit sequencer. It runs one Moore direction-detection FSM per gate, each driven by two optical sensors A (outer) and B (inner). It also has a per-gate stuck-sensor timeout and a shared, saturating occupancy counter with full/empty flags. It sits between the sensor synchronisers and the display/barrier logic.

Parameters:
N_PORTOES, 2, number of gates (sensor pairs), >=1
CAPACIDADE, 100, maximum number of parked vehicles, >=1
LARGURA, 8, occupancy width; CAPACIDADE <= 2^LARGURA-1 is required
TIMEOUT, 1000, cycles a gate FSM may stay unchanged outside IDLE before it aborts; 0 disables the timeout

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
A  input  N_PORTOES  outer sensor per gate, 1 = beam blocked (already synchronised)
B  input  N_PORTOES  inner sensor per gate, 1 = beam blocked
entrou  output  N_PORTOES  one-cycle pulse per gate: entry completed
saiu  output  N_PORTOES  one-cycle pulse per gate: exit completed
abortou  output  N_PORTOES  one-cycle pulse per gate: timeout abort
ocupacao  output  LARGURA  current vehicle count
cheio  output  1  ocupacao == CAPACIDADE
vazio  output  1  ocupacao == 0
erro_sat  output  1  one-cycle pulse: a count update was clamped

Behaviour:
- Reset is asynchronous and active-high. While it is asserted, every gate FSM is in IDLE, timers = 0, ocupacao = 0, erro_sat = 0. Outputs are then entrou = saiu = abortou = 0, vazio = 1 and cheio = 0. Reset mid-sequence discards the partial passage with no count.
- Gate FSM: one independent Moore FSM per gate. The input is {A[i],B[i]}.
  - IDLE: 10->E1; 01->S1; otherwise stay in IDLE.
  - E1: 10 stays; 11->E2; otherwise IDLE.
  - E2: 11 stays; 10->E1; 01->E3; 00->IDLE.
  - E3: 01 stays; 11->E2; 00->ENT; 10->IDLE.
  - ENT: go to IDLE unconditionally, whatever the inputs.
  - S1: 01 stays; 11->S2; otherwise IDLE.
  - S2: 11 stays; 01->S1; 10->S3; 00->IDLE.
  - S3: 10 stays; 11->S2; 00->SAI; 01->IDLE.
  - SAI: go to IDLE unconditionally.
  - ABT: go to IDLE unconditionally.
- Gate outputs are Moore-decoded from the state register: entrou[i] = (state==ENT), saiu[i] = (state==SAI), abortou[i] = (state==ABT). Each is exactly 1 cycle wide. The pulse appears in the cycle after the clock edge that sampled the final 00.
- Timeout:
  - Each gate has a timer of width clog2(TIMEOUT+1).
  - The timer clears to 0 in IDLE and on any state change. Otherwise it increments while the FSM is in E1..E3 or S1..S3.
  - When the timer == TIMEOUT-1 and the next state equals the current state, the next state becomes ABT instead.
  - With TIMEOUT = 0 the timer is held at 0 and ABT is never entered.
- Occupancy update (registered):
  - Each cycle, delta = popcount(entrou) - popcount(saiu), signed, over the range -N_PORTOES..+N_PORTOES.
  - nxt = ocupacao + delta, clamped to [0, CAPACIDADE].
  - ocupacao <= nxt on the next rising edge, so the count reflects a gate pulse one cycle after that pulse.
  - Simultaneous entries and exits on different gates net out before clamping. For example, 2 entries plus 1 exit at CAPACIDADE-1 gives CAPACIDADE with no error.
  - erro_sat <= 1 for one cycle, registered alongside ocupacao, iff the clamp changed the value.
- cheio and vazio are decoded combinationally from ocupacao. cheio does not block any gate FSM; barrier control is external.
- Arithmetic uses at least LARGURA+2 signed bits internally, so no intermediate wraps.

Test Plan:
- N_PORTOES=2, CAPACIDADE=3, TIMEOUT=8. Gate 0 sequence {A,B} = 10,11,01,00 with one cycle per step -> entrou[0]=1 for exactly 1 cycle, then ocupacao 0->1 one cycle later; vazio falls.
- Gate 1 exit sequence 01,11,10,00 from ocupacao=1 -> saiu[1] pulse, ocupacao=0, vazio=1. Repeating the exit at 0 -> ocupacao stays 0 and erro_sat pulses once.
- Reversal: gate 0 10,11,10,00 -> no pulse and ocupacao unchanged. Also 10,11,01,11,01,00 -> exactly one entrou pulse.
- Both gates finish an entry in the same cycle at ocupacao=2 -> ocupacao=3 (clamped from 4), cheio=1, erro_sat=1. Then entry on gate 0 with exit on gate 1 in the same cycle -> ocupacao stays 3 and erro_sat=0.
- Hold gate 0 at 11 for 8 cycles -> abortou[0] pulses, FSM returns to IDLE, no count change. The same test with TIMEOUT=0 -> no abort.
- Assert reset while gate 0 is in E3 with ocupacao=2 -> all outputs take their reset values immediately (asynchronously). After release, a following 00 produces no entrou.
